// File: rtl/role_axis_loopback.sv
// Role-side AXI-Stream loopback: XOR-masks each accepted word, buffers it in a
// synchronous FIFO and forwards it, truncating over-long packets and counting packets.
module role_axis_loopback #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_PKT_LEN = 256
) (
    input  logic                            sys_clk,
    input  logic                            perif_rst_n,

    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]         s_axis_tkeep,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,

    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,

    input  logic [DATA_WIDTH-1:0]           cfg_xor_mask,
    output logic [31:0]                     pkt_cnt,
    output logic                            trunc_err,
    input  logic                            err_clr,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int KEEP_W  = DATA_WIDTH / 8;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PW      = AW + 1;
    localparam int ENTRY_W = DATA_WIDTH + KEEP_W + 1;
    localparam int WCNT_W  = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_PKT_LEN - 1);

    typedef enum logic {
        ST_PASS,
        ST_DROP
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                rdy_en_q;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [31:0]         pkt_cnt_q;
    logic                trunc_q;

    logic full, empty;
    logic push, pop;
    logic tready;
    logic tlast_out;
    logic trunc_set;

    // Full when the pointers alias the same slot but differ in their wrap bit.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop   = !empty && m_axis_tready;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        push      = 1'b0;
        trunc_set = 1'b0;
        tready    = 1'b0;
        tlast_out = s_axis_tlast || (wcnt_q == WCNT_MAX);
        case (state_q)
            ST_PASS: begin
                tready = rdy_en_q && !full;
                if (s_axis_tvalid && tready) begin
                    push = 1'b1;
                    if (s_axis_tlast) begin
                        wcnt_d = '0;
                    end else if (wcnt_q == WCNT_MAX) begin
                        wcnt_d    = '0;
                        trunc_set = 1'b1;
                        state_d   = ST_DROP;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_DROP: begin
                tready = rdy_en_q;
                if (s_axis_tvalid && tready && s_axis_tlast) begin
                    state_d = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk or negedge perif_rst_n) begin
        if (!perif_rst_n) begin
            state_q  <= ST_PASS;
            wcnt_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge perif_rst_n) begin
        if (!perif_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_axis_tdata ^ cfg_xor_mask, s_axis_tkeep, tlast_out};
        end
    end

    always_ff @(posedge sys_clk or negedge perif_rst_n) begin
        if (!perif_rst_n) begin
            pkt_cnt_q <= '0;
            trunc_q   <= 1'b0;
        end else begin
            if (pop && m_axis_tlast) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            // A truncation in the same cycle as a clear request keeps the flag set.
            if (trunc_set)    trunc_q <= 1'b1;
            else if (err_clr) trunc_q <= 1'b0;
        end
    end

    assign s_axis_tready = tready;
    assign m_axis_tvalid = !empty;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = mem[rd_ptr_q[AW-1:0]];
    assign pkt_cnt       = pkt_cnt_q;
    assign trunc_err     = trunc_q;
    assign fifo_level    = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_role_axis_loopback.sv
// Self-checking bench for role_axis_loopback: scenario tasks plus a scoreboard of
// expected output beats derived per packet from the stimulus.
module tb_role_axis_loopback;

    localparam int DW      = 32;
    localparam int KW      = DW / 8;
    localparam int DEPTH   = 16;
    localparam int MAX_LEN = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          sys_clk = 1'b0;
    logic          perif_rst_n;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] cfg_xor_mask;
    logic [31:0]   pkt_cnt;
    logic          trunc_err;
    logic          err_clr;
    logic [4:0]    fifo_level;

    beat_t exp_q[$];
    beat_t mon_exp;
    int    tests_run    = 0;
    int    tests_failed = 0;

    always #5 sys_clk = ~sys_clk;

    role_axis_loopback #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .MAX_PKT_LEN(MAX_LEN)
    ) dut (
        .sys_clk      (sys_clk),
        .perif_rst_n  (perif_rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .cfg_xor_mask (cfg_xor_mask),
        .pkt_cnt      (pkt_cnt),
        .trunc_err    (trunc_err),
        .err_clr      (err_clr),
        .fifo_level   (fifo_level)
    );

    // Drive one word and hold it until the block accepts it (bounded wait).
    task automatic send_word(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic clr);
        int waited = 0;
        bit done   = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        err_clr       = clr;
        while (!done) begin
            @(negedge sys_clk);
            if (s_axis_tready) done = 1;
            @(posedge sys_clk);
            #1;
            err_clr = 1'b0;
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL accept_timeout: word %h not accepted, required acceptance within 200 cycles", d);
                    done = 1;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Expected output for a packet: only the first MAX_LEN words survive and the
    // MAX_LEN-th word carries tlast if the packet is longer.
    task automatic send_pkt(input int n, input logic [DW-1:0] base, input int clr_idx);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        for (int i = 0; i < n; i++) begin
            d = base + DW'(i);
            k = (i == n - 1) ? 4'h7 : 4'hF;
            l = (i == n - 1);
            if (i < MAX_LEN) exp_q.push_back('{d ^ cfg_xor_mask, k, l || (i == MAX_LEN - 1)});
            send_word(d, k, l, i == clr_idx);
        end
    endtask

    task automatic drain(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && c < 200) begin
            @(posedge sys_clk);
            #1;
            c++;
        end
        tests_run++;
        if (exp_q.size() != 0 || m_axis_tvalid) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d beats outstanding, tvalid=%b, required 0 and 0",
                     name, exp_q.size(), m_axis_tvalid);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge sys_clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        perif_rst_n   = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        cfg_xor_mask  = '0;
        err_clr       = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        tests_run++;
        if ({s_axis_tready, m_axis_tvalid, trunc_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: tready/tvalid/trunc=%b, required 000",
                     {s_axis_tready, m_axis_tvalid, trunc_err});
        end
        tests_run++;
        if (pkt_cnt !== 32'd0 || fifo_level !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_counts: pkt_cnt=%0d level=%0d, required 0 0", pkt_cnt, fifo_level);
        end
        perif_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        tests_run++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: tready=%b tvalid=%b, required 1 0", s_axis_tready, m_axis_tvalid);
        end
    endtask

    task automatic test_single();
        beat_t e;
        cfg_xor_mask  = 32'hFFFF_0000;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = '{32'hFFFF_0001 + DW'(i), (i == 3) ? 4'h7 : 4'hF, i == 3};
            exp_q.push_back(e);
            send_word(32'h1 + DW'(i), (i == 3) ? 4'h7 : 4'hF, i == 3, 1'b0);
            tests_run++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== e.data || fifo_level !== 5'd1) begin
                tests_failed++;
                $display("FAIL single_latency[%0d]: tvalid=%b data=%h level=%0d, required 1 %h 1",
                         i, m_axis_tvalid, m_axis_tdata, fifo_level, e.data);
            end
        end
        drain("single");
        tests_run++;
        if (pkt_cnt !== 32'd1 || trunc_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_status: pkt_cnt=%0d trunc=%b, required 1 0", pkt_cnt, trunc_err);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] cnt0;
        cnt0          = pkt_cnt;
        cfg_xor_mask  = 32'hA5A5_5A5A;
        m_axis_tready = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(4, 32'h100 + DW'(p * 16), -1);
        tests_run++;
        if (fifo_level !== 5'd16 || s_axis_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full: level=%0d tready=%b, required 16 0", fifo_level, s_axis_tready);
        end
        @(posedge sys_clk);
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold: tvalid=%b tready=%b, required 1 0", m_axis_tvalid, s_axis_tready);
        end
        m_axis_tready = 1'b1;
        send_pkt(4, 32'h140, -1);
        drain("bp");
        tests_run++;
        if (pkt_cnt !== cnt0 + 32'd5) begin
            tests_failed++;
            $display("FAIL bp_pkt_cnt: got %0d, required %0d", pkt_cnt, cnt0 + 32'd5);
        end
    endtask

    task automatic test_truncation();
        logic [31:0] cnt0;
        cnt0 = pkt_cnt;
        tests_run++;
        if (trunc_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL trunc_pre: trunc_err=%b, required 0", trunc_err);
        end
        send_pkt(6, 32'h200, -1);
        send_pkt(2, 32'h300, -1);
        drain("trunc");
        tests_run++;
        if (trunc_err !== 1'b1 || pkt_cnt !== cnt0 + 32'd2) begin
            tests_failed++;
            $display("FAIL trunc_status: trunc=%b pkt_cnt=%0d, required 1 %0d",
                     trunc_err, pkt_cnt, cnt0 + 32'd2);
        end
    endtask

    task automatic test_clear_vs_set();
        pulse_clr();
        tests_run++;
        if (trunc_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_alone1: trunc_err=%b, required 0", trunc_err);
        end
        send_pkt(5, 32'h400, 3);
        drain("clrset");
        tests_run++;
        if (trunc_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_vs_set: trunc_err=%b, required 1", trunc_err);
        end
        pulse_clr();
        tests_run++;
        if (trunc_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_alone2: trunc_err=%b, required 0", trunc_err);
        end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{(32'h500 + DW'(i)) ^ cfg_xor_mask, 4'hF, 1'b0});
            send_word(32'h500 + DW'(i), 4'hF, 1'b0, 1'b0);
        end
        m_axis_tready = 1'b1;
        @(posedge sys_clk);
        #1;
        m_axis_tready = 1'b0;
        tests_run++;
        if (fifo_level !== 5'd2) begin
            tests_failed++;
            $display("FAIL rstmid_level: got %0d, required 2", fifo_level);
        end
        #2;
        perif_rst_n = 1'b0;
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || fifo_level !== 5'd0 || s_axis_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_async: tvalid=%b level=%0d tready=%b, required 0 0 0",
                     m_axis_tvalid, fifo_level, s_axis_tready);
        end
        exp_q.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        perif_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        m_axis_tready = 1'b1;
        send_pkt(2, 32'h600, -1);
        drain("rstmid");
        tests_run++;
        if (pkt_cnt !== 32'd1 || trunc_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_after: pkt_cnt=%0d trunc=%b, required 1 0", pkt_cnt, trunc_err);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge sys_clk);
                if (perif_rst_n && m_axis_tvalid && m_axis_tready) begin
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL out_unexpected: data=%h last=%b, required no output",
                                 m_axis_tdata, m_axis_tlast);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== mon_exp) begin
                            tests_failed++;
                            $display("FAIL out_beat: data=%h keep=%h last=%b, required %h %h %b",
                                     m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                                     mon_exp.data, mon_exp.keep, mon_exp.last);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_single();
        test_backpressure();
        test_truncation();
        test_clear_vs_set();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
